priority_encoder_8_3: RTL and testbench
=======================================

# priority_encoder_8_3

Registered 8-to-3 priority encoder with request capture and a valid/ack handshake; the inverse of the 3-to-8 decoder. It samples eight active-low request lines, remembers requests in a pending register, and offers the highest-index pending request as a 3-bit code. The code is held stable until the consumer acknowledges it. It sits between asynchronous request sources (buttons, peripheral strobes) and a consumer that reads one event at a time.

## Interface

- LEVEL_MODE, default 0: 0 captures falling edges of I_n; 1 captures low levels.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- EI_n  input  1  enable, active-low; 1 blocks new captures.
- I_n  input  8  request lines, active-low; bit 7 has the highest priority.
- ack  input  1  consumer accepts the current code; meaningful only while valid=1.
- A  output  3  registered code of the offered request.
- valid  output  1  A holds an unacknowledged request.
- EO_n  output  1  registered; 0 when enabled and fully idle (pending==0 and valid==0 and EI_n==0).
- ovr  output  1  sticky flag: a request was captured on a bit that was already pending.

## Operation

- **Input stage**
  - s1 <= I_n every cycle; s2 <= s1 every cycle.
  - Edge mode: cap = s2 & ~s1 (falling edge).
  - Level mode: cap = ~s1.
  - cap is gated by EI_n==0 as sampled in the same cycle.
- **Pending register (8 bits)**
  - next = (pending & ~clr) | cap.
  - clr is a one-hot clear of bit A when state==OFFER and ack==1, otherwise 0.
  - Set beats clear on the same bit in the same cycle: the bit stays 1.
- **Overflow**
  - ovr <= 1 when any bit has cap==1 and pending==1 and is not being cleared that cycle.
  - ovr clears only on rst.
  - In level mode, a bit held low while already pending does not set ovr.
- **FSM states: IDLE, OFFER**
  - IDLE: valid=0. If pending != 0, load A with the index of the highest set pending bit, set valid<=1, and go to OFFER. Otherwise stay.
  - OFFER: valid=1 and A is frozen. New requests, including higher-priority ones, only set pending bits.
  - OFFER with ack=1: clear pending[A], set valid<=0, go to IDLE. A keeps its last value.
  - OFFER with ack=0: stay.
- ack while in IDLE is ignored and has no effect.
- EI_n=1 blocks captures only. Pending bits are still offered and drained normally.
- EO_n <= ~(EI_n==0 && pending==0 && state==IDLE && cap==0).
- **Reset values:** s1=s2=8'hFF, pending=0, state IDLE, A=0, valid=0, EO_n=1, ovr=0.
  - rst in the middle of OFFER discards all pending and offered requests.
  - The s1/s2 reset to 8'hFF prevents a false edge after reset.

## Timing

- Capture latency: I_n[j] is low at edge k (s2 high) -> pending[j]=1 after edge k+1 -> valid=1 and A=j after edge k+2.
- Handshake: ack sampled high at edge m -> valid=0 after edge m.
  - If other bits are pending, valid=1 again with the next code after edge m+1.
  - Peak throughput: one code per 2 cycles.
- Holding ack high continuously acknowledges each offer in its first OFFER cycle.
- EO_n lags the idle condition by one cycle.

## Test plan

- **Reset, then release:** I_n=8'hFF and EI_n=0 for 4 cycles -> valid=0, A=0, EO_n=0 from the second cycle after reset, ovr=0.
- **Single request:** pulse I_n[5] low for 1 cycle (edge k) -> valid=1 and A=5 after edge k+2. Pulse ack -> valid=0 next cycle and EO_n returns to 0.
- **Priority and freeze:**
  - Pulse I_n[2] low; once A=2 is offered, pulse I_n[7] and I_n[4] low -> A stays 2 until ack.
  - Then the codes follow in order 7, then 4, each needing an ack, with valid low for exactly 1 cycle between codes.
- **Overflow and set-beats-clear:**
  - Two falling edges on I_n[3] before any ack -> ovr=1, and only one code 3 is offered.
  - A new edge on bit 3 in the same cycle as ack of A=3 -> code 3 is offered again and ovr stays 0.
- **Enable and reset:**
  - With EI_n=1, pulse I_n[6] -> no capture and valid stays 0.
  - With pending=8'h41 and rst asserted during OFFER -> pending=0, valid=0, A=0, ovr=0 after that edge.
- **LEVEL_MODE=1:** hold I_n[1] low and ack each offer -> code 1 is re-offered every 2 cycles and ovr stays 0.

Source files
------------

// File: rtl/priority_encoder_8_3.sv
// Registered 8-to-3 priority encoder. Requests on eight active-low lines are captured into a
// pending register and offered one at a time, highest index first, through a valid/ack handshake.
module priority_encoder_8_3 #(
    parameter bit LEVEL_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EI_n,
    input  logic [7:0] I_n,
    input  logic       ack,
    output logic [2:0] A,
    output logic       valid,
    output logic       EO_n,
    output logic       ovr
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] s1_q, s2_q;
    logic [7:0] pend_q, pend_d;
    logic [2:0] a_q, a_d;
    logic       valid_q, valid_d;
    logic       eo_n_q, eo_n_d;
    logic       ovr_q, ovr_d;
    logic [7:0] fresh_s, cap_s, clr_s, ovr_hit_s;

    function automatic logic [2:0] highest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Capture, pending update, sticky overflow and idle indication.
    always_comb begin
        fresh_s = s2_q & ~s1_q;
        if (EI_n == 1'b0) begin
            cap_s = LEVEL_MODE ? ~s1_q : fresh_s;
        end else begin
            cap_s = 8'h00;
        end
        if ((state_q == OFFER) && ack) begin
            clr_s = 8'h01 << a_q;
        end else begin
            clr_s = 8'h00;
        end
        // A level held low on an already-pending bit is the same request, not a lost one.
        ovr_hit_s = cap_s & pend_q & ~clr_s & (LEVEL_MODE ? fresh_s : 8'hFF);
        pend_d    = (pend_q & ~clr_s) | cap_s;
        ovr_d     = ovr_q | (|ovr_hit_s);
        eo_n_d    = !((EI_n == 1'b0) && (pend_q == 8'h00) && (state_q == IDLE) && (cap_s == 8'h00));
    end

    // Offer/acknowledge state machine; A stays frozen while an offer is outstanding.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pend_q != 8'h00) begin
                    a_d     = highest_index(pend_q);
                    valid_d = 1'b1;
                    state_d = OFFER;
                end else begin
                    valid_d = 1'b0;
                end
            end
            OFFER: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; the synchronizer resets high so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 8'hFF;
            s2_q    <= 8'hFF;
            pend_q  <= 8'h00;
            state_q <= IDLE;
            a_q     <= 3'd0;
            valid_q <= 1'b0;
            eo_n_q  <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= I_n;
            s2_q    <= s1_q;
            pend_q  <= pend_d;
            state_q <= state_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            eo_n_q  <= eo_n_d;
            ovr_q   <= ovr_d;
        end
    end

    assign A     = a_q;
    assign valid = valid_q;
    assign EO_n  = eo_n_q;
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_priority_encoder_8_3.sv
// Randomized and directed bench for priority_encoder_8_3 in both capture modes, checked each
// cycle against a behavioural model of the request/offer rules.
module tb_priority_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst, EI_n, ack;
    logic [7:0] I_n;
    logic [2:0] a_e, a_l;
    logic       valid_e, valid_l, eon_e, eon_l, ovr_e, ovr_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = edge mode, 1 = level mode.
    logic [7:0] m_s1[2], m_s2[2], m_pend[2];
    logic [2:0] m_a[2];
    logic       m_valid[2], m_ovr[2], m_eon[2];

    priority_encoder_8_3 #(.LEVEL_MODE(1'b0)) dut_e (
        .clk(clk), .rst(rst), .EI_n(EI_n), .I_n(I_n), .ack(ack),
        .A(a_e), .valid(valid_e), .EO_n(eon_e), .ovr(ovr_e)
    );

    priority_encoder_8_3 #(.LEVEL_MODE(1'b1)) dut_l (
        .clk(clk), .rst(rst), .EI_n(EI_n), .I_n(I_n), .ack(ack),
        .A(a_l), .valid(valid_l), .EO_n(eon_l), .ovr(ovr_l)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int m);
        logic [7:0] np;
        bit         req, fresh, clr, any_req;
        int         hi;
        if (rst) begin
            m_s1[m] = 8'hFF; m_s2[m] = 8'hFF; m_pend[m] = 8'h00;
            m_a[m] = 3'd0; m_valid[m] = 1'b0; m_ovr[m] = 1'b0; m_eon[m] = 1'b1;
            return;
        end
        np = 8'h00;
        any_req = 1'b0;
        for (int j = 0; j < 8; j++) begin
            fresh = (m_s1[m][j] == 1'b0) && (m_s2[m][j] == 1'b1);
            req   = (EI_n == 1'b0) && ((m == 1) ? (m_s1[m][j] == 1'b0) : fresh);
            clr   = m_valid[m] && ack && (int'(m_a[m]) == j);
            if (req && m_pend[m][j] && !clr && ((m == 0) || fresh)) m_ovr[m] = 1'b1;
            np[j]   = req || (m_pend[m][j] && !clr);
            any_req = any_req || req;
        end
        m_eon[m] = !((EI_n == 1'b0) && (m_pend[m] == 8'h00) && !m_valid[m] && !any_req);
        if (m_valid[m]) begin
            if (ack) m_valid[m] = 1'b0;
        end else if (m_pend[m] != 8'h00) begin
            hi = 7;
            while (!m_pend[m][hi]) hi--;
            m_a[m]     = hi[2:0];
            m_valid[m] = 1'b1;
        end
        m_pend[m] = np;
        m_s2[m]   = m_s1[m];
        m_s1[m]   = I_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_eq("edge_A",     {5'd0, a_e},     {5'd0, m_a[0]});
        check_eq("edge_valid", {7'd0, valid_e}, {7'd0, m_valid[0]});
        check_eq("edge_EO_n",  {7'd0, eon_e},   {7'd0, m_eon[0]});
        check_eq("edge_ovr",   {7'd0, ovr_e},   {7'd0, m_ovr[0]});
        check_eq("lvl_A",      {5'd0, a_l},     {5'd0, m_a[1]});
        check_eq("lvl_valid",  {7'd0, valid_l}, {7'd0, m_valid[1]});
        check_eq("lvl_EO_n",   {7'd0, eon_l},   {7'd0, m_eon[1]});
        check_eq("lvl_ovr",    {7'd0, ovr_l},   {7'd0, m_ovr[1]});
    endtask

    task automatic pulse(input logic [7:0] mask);
        I_n = ~mask;
        tick();
        I_n = 8'hFF;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; EI_n = 1'b0; ack = 1'b0; I_n = 8'hFF;
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
        check_eq("reset_valid", {7'd0, valid_e}, 8'd0);
        check_eq("reset_A",     {5'd0, a_e},     8'd0);
        check_eq("reset_EO_n",  {7'd0, eon_e},   8'd0);
        check_eq("reset_ovr",   {7'd0, ovr_e},   8'd0);

        // Single request on bit 5.
        pulse(8'h20); tick(); tick();
        check_eq("single_valid", {7'd0, valid_e}, 8'd1);
        check_eq("single_A",     {5'd0, a_e},     8'd5);
        ack = 1'b1; tick(); ack = 1'b0;
        check_eq("single_ack_valid", {7'd0, valid_e}, 8'd0);
        tick();
        check_eq("single_EO_n", {7'd0, eon_e}, 8'd0);

        // Priority and freeze.
        pulse(8'h04); tick(); tick();
        check_eq("freeze_A0", {5'd0, a_e}, 8'd2);
        pulse(8'h90); tick(); tick(); tick();
        check_eq("freeze_A1", {5'd0, a_e}, 8'd2);
        ack = 1'b1; tick(); ack = 1'b0;
        check_eq("gap1_valid", {7'd0, valid_e}, 8'd0);
        tick();
        check_eq("next_A7", {5'd0, a_e}, 8'd7);
        ack = 1'b1; tick(); ack = 1'b0;
        check_eq("gap2_valid", {7'd0, valid_e}, 8'd0);
        tick();
        check_eq("next_A4", {5'd0, a_e}, 8'd4);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        check_eq("drained_valid", {7'd0, valid_e}, 8'd0);

        // Overflow: second edge on pending bit 3.
        pulse(8'h08); tick(); pulse(8'h08); tick();
        check_eq("ovr_set", {7'd0, ovr_e}, 8'd1);
        check_eq("ovr_A",   {5'd0, a_e},   8'd3);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        check_eq("ovr_single_code", {7'd0, valid_e}, 8'd0);

        // Set beats clear.
        rst = 1'b1; tick(); rst = 1'b0;
        pulse(8'h08); tick();
        I_n = 8'hF7; tick(); I_n = 8'hFF;
        check_eq("sbc_A", {5'd0, a_e}, 8'd3);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        check_eq("sbc_valid", {7'd0, valid_e}, 8'd1);
        check_eq("sbc_A2",    {5'd0, a_e},     8'd3);
        check_eq("sbc_ovr",   {7'd0, ovr_e},   8'd0);
        ack = 1'b1; tick(); ack = 1'b0; tick();

        // Enable blocks captures.
        EI_n = 1'b1;
        pulse(8'h40); tick(); tick(); tick();
        check_eq("ei_blocked", {7'd0, valid_e}, 8'd0);
        EI_n = 1'b0; tick();

        // Reset during OFFER with two pending requests.
        pulse(8'h41); tick(); tick();
        check_eq("rst_pre_A", {5'd0, a_e}, 8'd6);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_valid", {7'd0, valid_e}, 8'd0);
        check_eq("rst_A",     {5'd0, a_e},     8'd0);
        repeat (3) tick();
        check_eq("rst_no_reoffer", {7'd0, valid_e}, 8'd0);

        // Level mode: held request re-offered every two cycles.
        I_n = 8'hFD; ack = 1'b1;
        tick(); tick();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid_l) cnt++;
        end
        check_eq("lvl_reoffer_cnt", 8'(cnt), 8'd4);
        check_eq("lvl_reoffer_ovr", {7'd0, ovr_l}, 8'd0);
        I_n = 8'hFF; ack = 1'b0;
        repeat (3) tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] v;
            v = 8'h00;
            for (int b = 0; b < 8; b++) v[b] = ($urandom_range(0, 3) == 0);
            I_n  = ~v;
            EI_n = ($urandom_range(0, 7) == 0);
            ack  = ($urandom_range(0, 1) == 1);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
